// File: rtl/challenge_expander_seq.sv
`default_nettype none
//==============================================================================
// Module   : challenge_expander_seq
// Desc     : Expands one N_CB-bit master challenge into N_PUF per-PUF
//            challenges. The top slot holds the master challenge. Each lower
//            slot is the slot above it rotated by a shift amount that is
//            latched at accept time. Slots are built one per cycle in a shadow
//            register. The complete vector is then committed in one edge and
//            held until the downstream PUF array takes it.
// Ports    : clk         - system clock, rising edge
//            rst         - synchronous active-high reset
//            valid_i     - master challenge valid
//            ready_o     - block can accept a challenge (IDLE)
//            challenge_i - master challenge [N_CB]
//            shift_i     - rotation amount per slot step [SW]
//            mode_i      - 0 = rotate left, 1 = rotate right
//            valid_o     - expanded challenge vector valid
//            ready_i     - downstream accepts expanded vector
//            challenge_d - expanded vector, slot m at [m*N_CB +: N_CB]
//            busy_o      - high while expanding or committing
// Revision : 1.0 - initial release
//==============================================================================
module challenge_expander_seq #(
    parameter int N_CB  = 64,
    parameter int N_PUF = 16,
    parameter int SW    = $clog2(N_CB)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [N_CB-1:0]       challenge_i,
    input  logic [SW-1:0]         shift_i,
    input  logic                  mode_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [N_CB*N_PUF-1:0] challenge_d,
    output logic                  busy_o
);

    localparam int c_CNT_W = (N_PUF > 1) ? $clog2(N_PUF) : 1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_EXPAND = 2'd1;
    localparam logic [1:0] c_COMMIT = 2'd2;
    localparam logic [1:0] c_HOLD   = 2'd3;

    // The first slot written in EXPAND is N_PUF-2. A single-slot build skips
    // EXPAND, so the counter start value does not matter in that case.
    localparam logic [c_CNT_W-1:0] c_CNT_START = c_CNT_W'((N_PUF > 1) ? (N_PUF - 2) : 0);

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [SW-1:0]          r_shift;
    logic                   r_mode;
    logic [N_CB-1:0]        r_shadow [N_PUF];
    logic [N_CB*N_PUF-1:0]  r_dout;
    logic                   w_accept;
    logic [N_CB-1:0]        w_src;
    logic [N_CB-1:0]        w_rot;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (valid_i) begin
                    w_next_state = (N_PUF > 1) ? c_EXPAND : c_COMMIT;
                end
            end
            c_EXPAND: begin
                if (r_cnt == '0) begin
                    w_next_state = c_COMMIT;
                end
            end
            c_COMMIT: begin
                w_next_state = c_HOLD;
            end
            c_HOLD: begin
                if (ready_i) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // State-decoded outputs. valid_o is exactly "in HOLD", so it rises on the
    // commit edge and falls on the consume edge.
    always_comb begin
        ready_o = (r_state == c_IDLE);
        busy_o  = (r_state == c_EXPAND) || (r_state == c_COMMIT);
        valid_o = (r_state == c_HOLD);
    end

    assign w_accept    = valid_i & ready_o;
    assign challenge_d = r_dout;

    // Select the slot above the one being written. Then rotate it.
    // N_CB is a power of two, so SW-bit index arithmetic wraps modulo N_CB.
    always_comb begin
        w_src = '0;
        for (int m = 0; m < N_PUF - 1; m++) begin
            if (r_cnt == c_CNT_W'(m)) begin
                w_src = r_shadow[m+1];
            end
        end
        w_rot = '0;
        for (int i = 0; i < N_CB; i++) begin
            if (r_mode) begin
                w_rot[i] = w_src[SW'(i) + r_shift];
            end else begin
                w_rot[i] = w_src[SW'(i) - r_shift];
            end
        end
    end

    // Datapath: shadow build and atomic commit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_mode  <= 1'b0;
            r_dout  <= '0;
            for (int m = 0; m < N_PUF; m++) begin
                r_shadow[m] <= '0;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_shift            <= shift_i;
                        r_mode             <= mode_i;
                        r_shadow[N_PUF-1]  <= challenge_i;
                        r_cnt              <= c_CNT_START;
                    end
                end
                c_EXPAND: begin
                    for (int m = 0; m < N_PUF - 1; m++) begin
                        if (r_cnt == c_CNT_W'(m)) begin
                            r_shadow[m] <= w_rot;
                        end
                    end
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                c_COMMIT: begin
                    for (int m = 0; m < N_PUF; m++) begin
                        r_dout[m*N_CB +: N_CB] <= r_shadow[m];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
